// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between the requesting blocks (master) and the
// round-robin arbiter (slave).
interface ring_rr_arbiter_if #(
   parameter int N = 4
) ();
   localparam int OW = $clog2(N);

   logic [N-1:0]  req;
   logic          done;
   logic [N-1:0]  grant;
   logic [OW-1:0] owner;
   logic          busy;
   logic          timeout;

   modport master (output req, done, input grant, owner, busy, timeout);
   modport slave  (input req, done, output grant, owner, busy, timeout);
endinterface

// File: rtl/ring_rr_arbiter.sv
// Non-preemptive round-robin arbiter with a one-hot ring priority pointer.
// Define RR_HOLD_LIMIT_EN to force release after MAX_HOLD grant cycles.
module ring_rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input logic               clk,
   input logic               reset,
   ring_rr_arbiter_if.slave  bus
);
   localparam int OW = $clog2(N);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state_q,   state_d;
   logic [N-1:0]  grant_q,   grant_d;
   logic [N-1:0]  ptr_q,     ptr_d;
   logic [OW-1:0] owner_q,   owner_d;
   logic          busy_q,    busy_d;
   logic          timeout_q, timeout_d;

   logic [OW-1:0] ptr_idx;
   logic [OW:0]   cand;
   logic [OW-1:0] pick_idx;
   logic          pick_vld;
   logic          release_req;

`ifdef RR_HOLD_LIMIT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

   // Decode the one-hot pointer into an index
   always_comb begin
      ptr_idx = {OW{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (ptr_q[i]) begin
            ptr_idx = OW'(i);
         end else begin
            ptr_idx = ptr_idx;
         end
      end
   end

   // Scan from the pointer upward with wrap; smallest offset wins, so walk offsets high to low
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = {OW{1'b0}};
      cand     = {(OW+1){1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_idx} + (OW+1)'(k);
         if (cand >= (OW+1)'(N)) begin
            cand = cand - (OW+1)'(N);
         end else begin
            cand = cand;
         end
         if (bus.req[cand[OW-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[OW-1:0];
         end else begin
            pick_vld = pick_vld;
         end
      end
   end

   assign release_req = bus.done | ~bus.req[owner_q];

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
      hold_cnt_d = hold_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = GRANT;
               grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
               owner_d = pick_idx;
               busy_d  = 1'b1;
`ifdef RR_HOLD_LIMIT_EN
               hold_cnt_d = HW'(1);
`endif
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (release_req) begin
               state_d = IDLE;
               grant_d = {N{1'b0}};
               busy_d  = 1'b0;
               ptr_d   = {grant_q[N-2:0], grant_q[N-1]};
`ifdef RR_HOLD_LIMIT_EN
            end else if (hold_cnt_q >= HW'(MAX_HOLD)) begin
               // Forced release rotates exactly like a normal one
               state_d   = IDLE;
               grant_d   = {N{1'b0}};
               busy_d    = 1'b0;
               ptr_d     = {grant_q[N-2:0], grant_q[N-1]};
               timeout_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
`else
            end else begin
               state_d = GRANT;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = {N{1'b0}};
            busy_d  = 1'b0;
            ptr_d   = {{(N-1){1'b0}}, 1'b1};
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= {N{1'b0}};
         ptr_q     <= {{(N-1){1'b0}}, 1'b1};
         owner_q   <= {OW{1'b0}};
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef RR_HOLD_LIMIT_EN
         hold_cnt_q <= {HW{1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
`ifdef RR_HOLD_LIMIT_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   assign bus.grant   = grant_q;
   assign bus.owner   = owner_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: directed literal checks plus
// randomized traffic compared every cycle against an index-based reference model.
module tb_ring_rr_arbiter;
   localparam int N        = 4;
   localparam int MAX_HOLD = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   ring_rr_arbiter_if #(.N(N)) bus ();

   ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the resource and where the next scan starts
   int m_busy    = 0;
   int m_owner   = 0;
   int m_start   = 0;
   int m_timeout = 0;
   int m_hold    = 0;
   int m_valid   = 0;

   always @(posedge clk) begin : model
      int nb, no, ns, nt, nh;
      nb = m_busy; no = m_owner; ns = m_start; nt = 0; nh = m_hold;
      if (reset) begin
         nb = 0; no = 0; ns = 0; nh = 0;
      end else if (m_busy == 0) begin
         for (int k = 0; k < N; k++) begin
            if (nb == 0 && bus.req[(m_start + k) % N]) begin
               nb = 1; no = (m_start + k) % N; nh = 1;
            end
         end
      end else if (bus.done || !bus.req[m_owner]) begin
         nb = 0; ns = (m_owner + 1) % N;
`ifdef RR_HOLD_LIMIT_EN
      end else if (m_hold == MAX_HOLD) begin
         nb = 0; ns = (m_owner + 1) % N; nt = 1;
      end else begin
         nh = m_hold + 1;
`endif
      end
      m_busy    <= nb;
      m_owner   <= no;
      m_start   <= ns;
      m_timeout <= nt;
      m_hold    <= nh;
      if (reset) m_valid <= 1;
   end

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid != 0) begin
         chk("model_grant",   int'(bus.grant),   (m_busy != 0) ? (1 << m_owner) : 0);
         chk("model_owner",   int'(bus.owner),   m_owner);
         chk("model_busy",    int'(bus.busy),    m_busy);
         chk("model_timeout", int'(bus.timeout), m_timeout);
      end
   end

   task automatic drive(input logic [N-1:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      drive(4'b1111, 1'b0);
      // Reset held with all requests pending
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_grant", int'(bus.grant), 0);
         chk("rst_busy", int'(bus.busy), 0);
         chk("rst_timeout", int'(bus.timeout), 0);
      end
      reset = 1'b0;
      tick();
      chk("first_grant", int'(bus.grant), 4'b0001);
      chk("first_owner", int'(bus.owner), 0);
      drive(4'b1111, 1'b1); tick();
      chk("rel0", int'(bus.grant), 0);
      chk("rel0_owner_hold", int'(bus.owner), 0);

      drive(4'b0100, 1'b0); tick();
      chk("g2", int'(bus.grant), 4'b0100);
      chk("g2_owner", int'(bus.owner), 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("g2_hold", int'(bus.grant), 4'b0100);
      end
      drive(4'b0100, 1'b1); tick();
      chk("g2_done", int'(bus.grant), 0);
      drive(4'b1111, 1'b0); tick();
      chk("after2", int'(bus.grant), 4'b1000);
      chk("after2_owner", int'(bus.owner), 3);

      drive(4'b1111, 1'b1); tick();
      chk("gap", int'(bus.grant), 0);
      drive(4'b1111, 1'b0); tick();
      chk("rr0", int'(bus.grant), 4'b0001);
      for (int i = 1; i < 4; i++) begin
         drive(4'b1111, 1'b1); tick();
         chk("rr_gap", int'(bus.grant), 0);
         drive(4'b1111, 1'b0); tick();
         chk("rr_seq", int'(bus.grant), 1 << i);
      end
      drive(4'b1111, 1'b1); tick();
      chk("wrap_rel", int'(bus.grant), 0);

      drive(4'b0110, 1'b0); tick();
      chk("wrap_grant", int'(bus.grant), 4'b0010);
      drive(4'b1110, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("no_preempt", int'(bus.grant), 4'b0010);
      end

      reset = 1'b1; tick();
      chk("midrst_grant", int'(bus.grant), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      reset = 1'b0;
      drive(4'b0011, 1'b0); tick();
      chk("post_rst", int'(bus.grant), 4'b0001);
      drive(4'b0000, 1'b1); tick();
      chk("drop_rel", int'(bus.grant), 0);

      drive(4'b0000, 1'b1); tick();
      chk("idle_done", int'(bus.busy), 0);
      drive(4'b0100, 1'b1); tick();
      chk("idle_done_grant", int'(bus.grant), 4'b0100);
      drive(4'b0000, 1'b1); tick();
      chk("dual_rel", int'(bus.grant), 0);
      drive(4'b0100, 1'b0); tick();
      chk("regrant", int'(bus.grant), 4'b0100);
      drive(4'b0000, 1'b1); tick();
      chk("regrant_rel", int'(bus.grant), 0);

      drive(4'b0001, 1'b0); tick();
      chk("hold_start", int'(bus.grant), 4'b0001);
`ifdef RR_HOLD_LIMIT_EN
      for (int i = 1; i < MAX_HOLD; i++) begin
         tick();
         chk("hold_on", int'(bus.grant), 4'b0001);
         chk("hold_to0", int'(bus.timeout), 0);
      end
      tick();
      chk("forced_rel", int'(bus.grant), 0);
      chk("timeout_pulse", int'(bus.timeout), 1);
      drive(4'b0011, 1'b0); tick();
      chk("after_to", int'(bus.grant), 4'b0010);
      chk("timeout_clr", int'(bus.timeout), 0);
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_forever", int'(bus.grant), 4'b0001);
         chk("no_timeout", int'(bus.timeout), 0);
      end
`endif
      drive(4'b0000, 1'b1); tick();
      chk("end_rel", int'(bus.grant), 0);

      // Random traffic; the model compare process checks every cycle
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(99) == 0);
         if ($urandom_range(3) == 0) bus.req = 4'($urandom_range(15));
         bus.done = ($urandom_range(5) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
